// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: PC mux selects, IRQ FSM states
// and the default memory-stall timeout.
package pipe_ctrl_pkg;
  localparam logic [1:0] PC_SEL_PC4 = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JMP = 2'd2;
  localparam logic [1:0] PC_SEL_IRQ = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PEND    = 2'd1,
    ST_HANDLER = 2'd2
  } irq_state_t;

  localparam int STALL_TIMEOUT_DEF = 255;
endpackage

// File: rtl/pipe_irq_fsm.sv
// Interrupt-entry sequencer: latches a request until a clean pipeline cycle,
// then fires a one-cycle take and sits in HANDLER until eret.
module pipe_irq_fsm
  import pipe_ctrl_pkg::*;
(
  input  logic sysclk,
  input  logic reset,
  input  logic clean,
  input  logic irq_req,
  input  logic irq_en,
  input  logic id_eret,
  input  logic mem_busy,
  output logic take,
  output logic in_handler
);
  irq_state_t r_state, w_next;

  always_ff @(posedge sysclk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    take   = 1'b0;
    if (!reset) begin
      unique case (r_state)
        ST_RUN: if (irq_req && irq_en) begin
          take   = clean;
          w_next = clean ? ST_HANDLER : ST_PEND;
        end
        // Request is already latched here, so irq_req no longer matters.
        ST_PEND: if (!irq_en) begin
          w_next = ST_RUN;
        end else if (clean) begin
          take   = 1'b1;
          w_next = ST_HANDLER;
        end
        ST_HANDLER: if (id_eret && !mem_busy) w_next = ST_RUN;
        default: w_next = ST_RUN;
      endcase
    end
  end

  assign in_handler = (r_state == ST_HANDLER);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register enables, flushes, holds and PC select for the 5-stage core.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_jump,
  input  logic       id_eret,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       mem_busy,
  input  logic       irq_req,
  input  logic       irq_en,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       if_id_write,
  output logic       if_flush,
  output logic       id_ex_flush,
  output logic       pipe_hold,
  output logic       irq_ack,
  output logic       epc_capture,
  output logic       in_handler,
  output logic       stall_err
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_stall_cnt
  , output logic [CNT_W-1:0] perf_flush_cnt
  , output logic [CNT_W-1:0] perf_irq_cnt
`endif
);
  localparam int            CW   = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_V = CW'(STALL_TIMEOUT);

  logic          w_load_use, w_clean, w_take;
  logic [CW-1:0] r_stall_cnt;
  logic          r_stall_err;

  assign w_load_use = ex_mem_read && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
  assign w_clean    = !mem_busy && !ex_branch_taken && !w_load_use && !id_jump;

  pipe_irq_fsm u_irq_fsm (
    .sysclk     (sysclk),
    .reset      (reset),
    .clean      (w_clean),
    .irq_req    (irq_req),
    .irq_en     (irq_en),
    .id_eret    (id_eret),
    .mem_busy   (mem_busy),
    .take       (w_take),
    .in_handler (in_handler)
  );

  always_comb begin
    pc_write    = 1'b1;
    pc_sel      = PC_SEL_PC4;
    if_id_write = 1'b1;
    if_flush    = 1'b0;
    id_ex_flush = 1'b0;
    pipe_hold   = 1'b0;
    irq_ack     = 1'b0;
    epc_capture = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_flush    = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      // Freeze everything; lower-priority events are re-seen next cycle.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (ex_branch_taken) begin
      pc_sel      = PC_SEL_BR;
      if_flush    = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (id_jump) begin
      pc_sel      = PC_SEL_JMP;
      if_flush    = 1'b1;
    end else if (w_take) begin
      pc_sel      = PC_SEL_IRQ;
      if_flush    = 1'b1;
      irq_ack     = 1'b1;
      epc_capture = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else if (mem_busy) begin
      if (r_stall_cnt != TO_V)          r_stall_cnt <= r_stall_cnt + 1'b1;
      if (r_stall_cnt >= TO_V - 1'b1)   r_stall_err <= 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  assign stall_err = r_stall_err;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge sysclk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_irq_cnt   <= '0;
    end else begin
      if (w_load_use || mem_busy) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (if_flush)               perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (irq_ack)                perf_irq_cnt   <= perf_irq_cnt + 1'b1;
    end
  end
`endif
endmodule
